// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch sequencer: one outstanding imem request,
// valid/ready to decode, branch-offset redirect. `FETCH_PREFETCH_EN adds a one-entry prefetch buffer.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  output logic        oIMEM_REQ,
  output logic [31:0] oIMEM_ADDR,
  input  logic        iIMEM_GNT,
  input  logic        iIMEM_RVALID,
  input  logic [31:0] iIMEM_RDATA,
  output logic [31:0] oIR,
  output logic [31:0] oPC,
  output logic        oIR_VALID,
  input  logic        iIR_READY,
  input  logic        iBR_VALID,
  input  logic [31:0] iPCBR,
  output logic        oFAULT
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic [2:0]  r_state;
  logic        r_req;
  logic [31:0] r_addr;
  logic [31:0] r_ir;
  logic [31:0] r_pc;
  logic        r_vld;
  logic        r_fault;

  logic        w_consume;
  logic        w_taken;
  logic [31:0] w_next;
  logic        w_misal;

  // oIR_VALID is only ever set while in HOLD, so this is the consume strobe.
  assign w_consume = r_vld & iIR_READY;
  assign w_taken   = iBR_VALID && (iPCBR != 32'h0);
  assign w_next    = r_pc + (w_taken ? iPCBR : 32'd4);
  assign w_misal   = |w_next[1:0];

`ifdef FETCH_PREFETCH_EN
  logic        r_pfw;       // prefetch granted, response not yet back
  logic        r_buf_vld;
  logic [31:0] r_buf_ir;
  logic [31:0] r_buf_pc;
  logic        r_drop;      // discard the next response (stale prefetch)
  logic        w_pend;
  // A request that will still be outstanding after this edge.
  assign w_pend = (r_pfw && !iIMEM_RVALID) || (r_req && iIMEM_GNT);
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state   <= S_IDLE;
      r_req     <= 1'b0;
      r_addr    <= RESET_PC;
      r_ir      <= 32'h0;
      r_pc      <= RESET_PC;
      r_vld     <= 1'b0;
      r_fault   <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      r_pfw     <= 1'b0;
      r_buf_vld <= 1'b0;
      r_buf_ir  <= 32'h0;
      r_buf_pc  <= 32'h0;
      r_drop    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
        end
        S_REQ: begin
`ifdef FETCH_PREFETCH_EN
          if (r_drop) begin
            if (iIMEM_RVALID) begin
              r_drop <= 1'b0;
              r_req  <= 1'b1;
            end
          end else
`endif
          if (r_req && iIMEM_GNT) begin
            r_req   <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (iIMEM_RVALID) begin
            r_ir    <= iIMEM_RDATA;
            r_pc    <= r_addr;
            r_vld   <= 1'b1;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_consume) begin
            if (w_misal) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
              r_vld   <= 1'b0;
              r_req   <= 1'b0;
`ifdef FETCH_PREFETCH_EN
              r_pfw     <= 1'b0;
              r_buf_vld <= 1'b0;
              r_drop    <= 1'b0;
`endif
            end else begin
`ifdef FETCH_PREFETCH_EN
              r_buf_vld <= 1'b0;
              r_pfw     <= 1'b0;
              if (w_taken) begin
                r_vld   <= 1'b0;
                r_addr  <= w_next;
                r_state <= S_REQ;
                r_drop  <= w_pend;
                r_req   <= !w_pend;
              end else if (r_buf_vld) begin
                r_ir <= r_buf_ir;
                r_pc <= r_buf_pc;
              end else if (r_pfw && iIMEM_RVALID) begin
                r_ir <= iIMEM_RDATA;
                r_pc <= r_addr;
              end else if (w_pend) begin
                r_vld   <= 1'b0;
                r_req   <= 1'b0;
                r_state <= S_WAIT;
              end else begin
                // covers an ungranted prefetch too: its address already equals w_next
                r_vld   <= 1'b0;
                r_req   <= 1'b1;
                r_addr  <= w_next;
                r_state <= S_REQ;
              end
`else
              r_vld   <= 1'b0;
              r_req   <= 1'b1;
              r_addr  <= w_next;
              r_state <= S_REQ;
`endif
            end
          end
`ifdef FETCH_PREFETCH_EN
          else if (r_req && iIMEM_GNT) begin
            r_req <= 1'b0;
            r_pfw <= 1'b1;
          end else if (r_pfw && iIMEM_RVALID) begin
            r_pfw     <= 1'b0;
            r_buf_vld <= 1'b1;
            r_buf_ir  <= iIMEM_RDATA;
            r_buf_pc  <= r_addr;
          end else if (!r_req && !r_pfw && !r_buf_vld) begin
            r_req  <= 1'b1;
            r_addr <= r_pc + 32'd4;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign oIMEM_REQ  = r_req;
  assign oIMEM_ADDR = r_addr;
  assign oIR        = r_ir;
  assign oPC        = r_pc;
  assign oIR_VALID  = r_vld;
  assign oFAULT     = r_fault;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized scoreboard bench for fetch_pc_unit: a memory responder, a decode-side driver
// that predicts the PC stream from the branch rules, and a monitor comparing each new oPC/oIR.
module tb_fetch_pc_unit;
  localparam logic [31:0] RPC = 32'h100;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic        oIMEM_REQ;
  logic [31:0] oIMEM_ADDR;
  logic        iIMEM_GNT;
  logic        iIMEM_RVALID;
  logic [31:0] iIMEM_RDATA;
  logic [31:0] oIR;
  logic [31:0] oPC;
  logic        oIR_VALID;
  logic        iIR_READY;
  logic        iBR_VALID;
  logic [31:0] iPCBR;
  logic        oFAULT;

  fetch_pc_unit #(.RESET_PC(RPC)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .oIMEM_REQ(oIMEM_REQ), .oIMEM_ADDR(oIMEM_ADDR), .iIMEM_GNT(iIMEM_GNT),
    .iIMEM_RVALID(iIMEM_RVALID), .iIMEM_RDATA(iIMEM_RDATA),
    .oIR(oIR), .oPC(oPC), .oIR_VALID(oIR_VALID), .iIR_READY(iIR_READY),
    .iBR_VALID(iBR_VALID), .iPCBR(iPCBR), .oFAULT(oFAULT)
  );

  always #5 iCLK = ~iCLK;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb_q[$];   // {expected oPC, expected oIR}
  logic need_check = 1'b0;

  logic        dir_bv  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [31:0] dir_off [5] = '{32'h0, 32'hFFFF_FFF8, 32'hFFFF_FF00, 32'h40, 32'h200};
  logic [31:0] offs    [8] = '{32'h0, 32'h4, 32'h8, 32'hFFFF_FFF8, 32'h100,
                               32'hFFFF_FFC0, 32'h1000, 32'hFFFF_FFFC};

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Instruction memory: random grant/latency, one 5-cycle grant stall with a stray rvalid.
  initial begin
    int pend, cnt, nreq, blk;
    logic [31:0] paddr, prev_addr;
    logic prev_wait;
    pend = 0; cnt = 0; nreq = 0; blk = 0; prev_wait = 1'b0; paddr = 0; prev_addr = 0;
    iIMEM_GNT = 1'b0; iIMEM_RVALID = 1'b0; iIMEM_RDATA = 32'h0;
    forever begin
      @(negedge iCLK);
      iIMEM_GNT = 1'b0; iIMEM_RVALID = 1'b0; iIMEM_RDATA = $urandom;
      if (!iRST_N) begin
        pend = 0; nreq = 0; blk = 0; prev_wait = 1'b0;
        continue;
      end
`ifndef FETCH_PREFETCH_EN
      if (prev_wait) begin
        chk("req_held", {31'h0, oIMEM_REQ}, 32'h1);
        chk("addr_stable", oIMEM_ADDR, prev_addr);
      end
`endif
      prev_wait = 1'b0;
      if (pend != 0) begin
        if (cnt == 0) begin
          iIMEM_RVALID = 1'b1; iIMEM_RDATA = memfn(paddr); pend = 0;
        end else cnt--;
      end else if (oIMEM_REQ) begin
        if (nreq == 3 && blk < 5) begin
          blk++; prev_wait = 1'b1; prev_addr = oIMEM_ADDR;
          if (blk == 2) iIMEM_RVALID = 1'b1;
        end else if (nreq == 0 || nreq == 3 || $urandom_range(2) != 0) begin
          iIMEM_GNT = 1'b1; pend = 1; paddr = oIMEM_ADDR;
          cnt = (nreq == 0) ? 0 : int'($urandom_range(2));
          nreq++;
        end else begin
          prev_wait = 1'b1; prev_addr = oIMEM_ADDR;
        end
      end else if ($urandom_range(5) == 0) begin
        iIMEM_RVALID = 1'b1;
      end
    end
  end

  // Monitor: each newly presented instruction is checked against the scoreboard head.
  initial begin
    int wait_cyc;
    logic [63:0] e;
    wait_cyc = 0;
    forever begin
      @(negedge iCLK);
      if (need_check && iRST_N) begin
        if (oIR_VALID) begin
          if (sb_q.size() == 0) begin
            chk("sb_empty", {31'h0, oIR_VALID}, 32'h0);
          end else begin
            e = sb_q.pop_front();
            chk("opc", oPC, e[63:32]);
            chk("oir", oIR, e[31:0]);
          end
          need_check = 1'b0; wait_cyc = 0;
        end else if (++wait_cyc > 60) begin
          chk("ir_timeout", {31'h0, oIR_VALID}, 32'h1);
          need_check = 1'b0; wait_cyc = 0;
        end
      end else wait_cyc = 0;
    end
  end

  task automatic drain();
    for (int i = 0; i < 100 && need_check; i++) @(negedge iCLK);
  endtask

  // Decode-side driver and PC reference model.
  initial begin
    logic [31:0] exp_pc, nxt, off;
    logic cons, bv;
    int ncons, t1, t2, nreq_seen;
    ncons = 0;
    iRST_N = 1'b0; iIR_READY = 1'b0; iBR_VALID = 1'b0; iPCBR = 32'h0;
    repeat (2) @(negedge iCLK);
    chk("rst_req",   {31'h0, oIMEM_REQ}, 32'h0);
    chk("rst_addr",  oIMEM_ADDR, RPC);
    chk("rst_ir",    oIR, 32'h0);
    chk("rst_pc",    oPC, RPC);
    chk("rst_vld",   {31'h0, oIR_VALID}, 32'h0);
    chk("rst_fault", {31'h0, oFAULT}, 32'h0);

    exp_pc = RPC;
    sb_q.push_back({RPC, memfn(RPC)}); need_check = 1'b1;
    iRST_N = 1'b1;
    t1 = -1; t2 = -1;
    for (int c = 0; c < 20 && t2 < 0; c++) begin
      @(negedge iCLK);
      if (t1 < 0 && oIMEM_REQ) begin
        t1 = c; chk("first_addr", oIMEM_ADDR, RPC);
      end
      if (oIR_VALID) t2 = c;
    end
    chk("first_latency", 32'(t2 - t1), 32'd2);

    for (int cyc = 0; cyc < 6000 && ncons < 150; cyc++) begin
      @(negedge iCLK);
      iIR_READY = ($urandom_range(2) != 0);
      cons = oIR_VALID && iIR_READY;
      if (cons) begin
        if (ncons < 5) begin bv = dir_bv[ncons]; off = dir_off[ncons]; end
        else begin bv = $urandom_range(1) == 1; off = offs[$urandom_range(7)]; end
      end else begin
        bv = 1'b1; off = {$urandom, 2'b10};   // misaligned junk that must not be sampled
      end
      iBR_VALID = bv; iPCBR = off;
      @(posedge iCLK); #1;
      if (cons) begin
        nxt = exp_pc + ((bv && off != 32'h0) ? off : 32'd4);
        exp_pc = nxt; ncons++;
        sb_q.push_back({nxt, memfn(nxt)}); need_check = 1'b1;
      end
    end
    chk("consume_count", 32'(ncons), 32'd150);
    iIR_READY = 1'b0;
    drain();

    // Misaligned branch target from RESET_PC.
    iRST_N = 1'b0;
    repeat (2) @(negedge iCLK);
    sb_q.delete();
    sb_q.push_back({RPC, memfn(RPC)}); need_check = 1'b1;
    iRST_N = 1'b1;
    drain();
    @(negedge iCLK);
    chk("pre_fault_vld", {31'h0, oIR_VALID}, 32'h1);
    iIR_READY = 1'b1; iBR_VALID = 1'b1; iPCBR = 32'h6;
    @(negedge iCLK);
    iIR_READY = 1'b0; iBR_VALID = 1'b0; iPCBR = 32'h0;
    chk("fault_set", {31'h0, oFAULT}, 32'h1);
    chk("fault_vld", {31'h0, oIR_VALID}, 32'h0);
    chk("fault_req", {31'h0, oIMEM_REQ}, 32'h0);
    nreq_seen = 0;
    repeat (20) begin
      @(negedge iCLK);
      if (oIMEM_REQ) nreq_seen++;
    end
    chk("fault_no_req", 32'(nreq_seen), 32'd0);
    chk("fault_sticky", {31'h0, oFAULT}, 32'h1);
    iRST_N = 1'b0;
    @(negedge iCLK);
    chk("fault_cleared", {31'h0, oFAULT}, 32'h0);
    iRST_N = 1'b1;
    repeat (2) @(negedge iCLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
